// File: rtl/control_sequencer_pkg.sv
// Shared constants for the CPU control sequencer: opcodes, FSM states,
// branch condition codes and ALU flag bit positions.
package control_sequencer_pkg;

  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_LOAD  = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_WAIT  = 4'hF;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_JUMP   = 4'd3,
    S_LOAD1  = 4'd4,
    S_LOAD2  = 4'd5,
    S_STORE  = 4'd6,
    S_WAIT   = 4'd7,
    S_BRANCH = 4'd8
  } state_e;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_LO = 4'd6;
  localparam logic [3:0] CC_HS = 4'd7;
  localparam logic [3:0] CC_AL = 4'd14;

  // alu_flags / saved_flags = {N,Z,F,L,C}
  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

endpackage

// File: rtl/control_sequencer_wait_timer.sv
// Millisecond timer: prescaler divides clk by CLK_PER_MS, ms counts ticks
// and saturates at all-ones. clear has priority over enable.
module control_sequencer_wait_timer #(
  parameter int CLK_PER_MS = 166667,
  parameter int WAIT_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  output logic [WAIT_WIDTH-1:0] ms
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
      ms  <= '0;
    end else if (clear) begin
      pre <= '0;
      ms  <= '0;
    end else if (enable) begin
      if (pre == PRE_LAST) begin
        pre <= '0;
        if (ms != '1) ms <= ms + WAIT_WIDTH'(1);
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit CPU datapath: owns PC,
// IR and saved flags, drives all datapath strobes as Moore decodes of state.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH     = 15,
  parameter int                  INSTR_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] PC_RESET     = {PC_WIDTH{1'b1}},
  parameter bit                  PC_STEP_DOWN = 1'b1,
  parameter int                  CLK_PER_MS   = 166667,
  parameter int                  WAIT_WIDTH   = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   mem_ready,
  input  logic [INSTR_WIDTH-1:0] alu_c,
  input  logic [4:0]             alu_flags,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   addr_sel,
  output logic                   mem_we,
  output logic                   reg_we,
  output logic                   wb_sel,
  output logic                   alu_ovr,
  output logic [INSTR_WIDTH-1:0] alu_ovr_op,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [4:0]             saved_flags,
  output logic                   waiting
);

  state_e                state, state_nxt;
  logic [PC_WIDTH-1:0]   pc_seq, pc_br;
  logic [WAIT_WIDTH-1:0] ms;
  logic                  wait_done, br_taken;
  logic                  unused_alu_c;

  assign unused_alu_c = &{1'b0, alu_c[INSTR_WIDTH-1:PC_WIDTH]};

  assign pc_seq     = PC_STEP_DOWN ? pc - PC_WIDTH'(1) : pc + PC_WIDTH'(1);
  assign pc_br      = pc + {{(PC_WIDTH-8){ir[7]}}, ir[7:0]};
  assign wait_done  = (ms == ir[WAIT_WIDTH-1:0]);
  assign alu_ovr_op = {OP_ADDI, ir[11:8], {(INSTR_WIDTH-8){1'b0}}};

  control_sequencer_wait_timer #(
    .CLK_PER_MS(CLK_PER_MS),
    .WAIT_WIDTH(WAIT_WIDTH)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .enable(state == S_WAIT),
    .clear (state == S_WAIT && wait_done),
    .ms    (ms)
  );

  always_comb begin
    br_taken = 1'b0;
    case (ir[11:8])
      CC_EQ:   br_taken =  saved_flags[FLAG_Z];
      CC_NE:   br_taken = !saved_flags[FLAG_Z];
      CC_CS:   br_taken =  saved_flags[FLAG_C];
      CC_CC:   br_taken = !saved_flags[FLAG_C];
      CC_MI:   br_taken =  saved_flags[FLAG_N];
      CC_PL:   br_taken = !saved_flags[FLAG_N];
      CC_LO:   br_taken =  saved_flags[FLAG_L];
      CC_HS:   br_taken = !saved_flags[FLAG_L];
      CC_AL:   br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_sel  = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b1;
    alu_ovr   = 1'b0;
    waiting   = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (instr[INSTR_WIDTH-1 -: 4])
          OP_JMP:   state_nxt = S_JUMP;
          OP_LOAD:  state_nxt = S_LOAD1;
          OP_STORE: state_nxt = S_STORE;
          OP_WAIT:  state_nxt = S_WAIT;
          OP_BCOND: state_nxt = S_BRANCH;
          default:  state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        reg_we    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        alu_ovr   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_LOAD1: begin
        addr_sel = 1'b1;
        if (mem_ready) state_nxt = S_LOAD2;
      end
      S_LOAD2: begin
        addr_sel  = 1'b1;
        wb_sel    = 1'b0;
        reg_we    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_STORE: begin
        addr_sel = 1'b1;
        alu_ovr  = 1'b1;
        mem_we   = 1'b1;
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_WAIT: begin
        if (wait_done) state_nxt = S_FETCH;
        else           waiting   = 1'b1;
      end
      S_BRANCH: state_nxt = S_FETCH;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // PC, IR and flags only move in the state that owns the update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= PC_RESET;
      ir          <= '0;
      saved_flags <= '0;
    end else begin
      case (state)
        S_DECODE: ir <= instr;
        S_EXEC: begin
          saved_flags <= alu_flags;
          pc          <= pc_seq;
        end
        S_JUMP:   pc <= alu_c[PC_WIDTH-1:0];
        S_LOAD2:  pc <= pc_seq;
        S_STORE:  if (mem_ready) pc <= pc_seq;
        S_WAIT:   if (wait_done) pc <= pc_seq;
        S_BRANCH: pc <= br_taken ? pc_br : pc_seq;
        default:  ;
      endcase
    end
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised multi-cycle instruction sequencer; next-generation controller for the 16-bit CPU datapath (memory, register file, ALU).
- Owns the PC, the instruction register and the saved-flags register, and the millisecond WAIT timer.
- Drives every datapath control line, with several additions:
  - a memory-ready handshake (wait states);
  - conditional PC-relative branches on saved flags;
  - a latched instruction register;
  - a parametrised timer tick.

Parameters:
- PC_WIDTH, 15, PC/address width.
- INSTR_WIDTH, 16, instruction/data width (opcode always in top 4 bits).
- PC_RESET, {PC_WIDTH{1'b1}}, PC value after reset.
- PC_STEP_DOWN, 1, 1: sequential PC decrements by 1; 0: increments by 1.
- CLK_PER_MS, 166667, clk cycles per WAIT millisecond tick (must be >=1).
- WAIT_WIDTH, 12, width of millisecond counter and WAIT operand.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  INSTR_WIDTH  memory port A read data.
- mem_ready  in  1  memory completed current access (read data valid / write accepted).
- alu_c  in  INSTR_WIDTH  ALU result (jump target).
- alu_flags  in  5  ALU flags {N,Z,F,L,C}, bit0=C.
- pc  out  PC_WIDTH  program counter.
- addr_sel  out  1  0: memory address = pc; 1: address = reg_b.
- mem_we  out  1  memory port A write strobe.
- reg_we  out  1  register-file write enable.
- wb_sel  out  1  1: write back ALU result; 0: write back memory data.
- alu_ovr  out  1  1: ALU opcode = alu_ovr_op; 0: ALU opcode = ir.
- alu_ovr_op  out  INSTR_WIDTH  forced ALU opcode {OP_ADDI, ir[11:8], 8'h00}.
- ir  out  INSTR_WIDTH  latched instruction; rd = ir[11:8], rs = ir[3:0].
- saved_flags  out  5  flags register; carry_in = saved_flags[0].
- waiting  out  1  high while in WAIT state with count not reached.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, pc=PC_RESET, ir=0, saved_flags=0, ms=0, prescaler=0.
  - All strobes 0; wb_sel=1, addr_sel=0.
  - Reset asserted mid-STORE drops mem_we immediately.
  - No partial PC or flag update survives reset.
- Strobes are Moore decodes of state (and ir); no output depends combinationally on mem_ready.
- FETCH: addr_sel=0. Stay until mem_ready=1, then DECODE.
- DECODE:
  - ir <= instr.
  - Next state from instr[15:12]: OP_JMP->JUMP, OP_LOAD->LOAD1, OP_STORE->STORE, OP_WAIT->WAIT, OP_BCOND->BRANCH, else EXEC.
- EXEC: reg_we=1, saved_flags <= alu_flags, pc steps; ->FETCH.
- JUMP: alu_ovr=1, pc <= alu_c[PC_WIDTH-1:0]; flags unchanged; ->FETCH.
- LOAD1: addr_sel=1; stay until mem_ready, then LOAD2.
- LOAD2: addr_sel=1, wb_sel=0, reg_we=1, pc steps; ->FETCH.
- STORE:
  - addr_sel=1, alu_ovr=1, mem_we=1, held until mem_ready.
  - On mem_ready: pc steps, ->FETCH.
- BRANCH:
  - cond=ir[11:8]; codes: 0 EQ(Z), 1 NE(!Z), 2 CS(C), 3 CC(!C), 4 MI(N), 5 PL(!N), 6 LO(L), 7 HS(!L), 14 AL; all other codes never taken.
  - Taken: pc <= pc + sign-extended ir[7:0] (wraps modulo 2^PC_WIDTH).
  - Not taken: pc steps.
  - ->FETCH.
- WAIT:
  - Prescaler counts 0..CLK_PER_MS-1; on terminal count it returns to 0 and ms increments.
  - When ms == ir[WAIT_WIDTH-1:0]: pc steps, ms and prescaler clear, ->FETCH.
  - waiting=1 otherwise.
  - WAIT 0 exits on first WAIT cycle.
  - ms saturates at all-ones (no wrap).
- "pc steps" means pc +/- 1 per PC_STEP_DOWN, modulo 2^PC_WIDTH (0 steps down to all-ones).
- Latency with mem_ready tied 1: EXEC/JUMP/BRANCH 3 cycles; STORE 3; LOAD 4; WAIT n: 3 + n*CLK_PER_MS cycles.
- Each mem_ready stall cycle adds one cycle in FETCH, LOAD1 or STORE.
- Illegal state encodings recover to FETCH.

Decomposition:
- Shared include parameters.vh holds:
  - opcode constants: OP_JMP=4'h4, OP_LOAD=4'h6, OP_STORE=4'h7, OP_WAIT=4'hF, OP_BCOND=4'hC, OP_ADDI=4'h5;
  - state encodings FETCH..BRANCH (0..8);
  - condition-code constants;
  - flag bit indices.
- One natural sub-module: wait_timer (prescaler + saturating ms counter, inputs enable/clear, output ms), reusable by peripherals.

Test Plan:
- Reset: release with PC_RESET=15'h7FFF, PC_STEP_DOWN=1, instr=ADD R1,R2 (16'h0102), mem_ready=1 -> reg_we pulses in cycle 3, pc=7FFE after 3 cycles, saved_flags = alu_flags.
- Memory stall: LOAD (16'h6103) with mem_ready low 2 cycles in LOAD1 -> reg_we with wb_sel=0 in cycle 6, addr_sel=1 throughout LOAD1/LOAD2.
- Conditional branch: saved_flags Z=1, BEQ disp -3 (16'hC0FD) at pc=0x0010, PC_STEP_DOWN=0 -> pc=0x000D. Same instruction with Z=0 -> pc=0x0011. Cond 9 -> never taken.
- Timer: CLK_PER_MS=4, WAIT 3 (16'hF003) -> waiting high exactly 12 cycles, pc steps once, ms back to 0. WAIT 0 -> 3 total cycles.
- Reset mid-operation: reset low during STORE with mem_ready=0 -> mem_we falls same cycle (async), pc=PC_RESET, state FETCH.
- Wrap: pc=0, PC_STEP_DOWN=1, EXEC -> pc=7FFF. JUMP with alu_c=16'hFFFF -> pc=7FFF (truncation), flags unchanged.
